// File: rtl/fwnoc_fifo_p_pkg.sv
// Shared types and helpers for the fwnoc_fifo_p FIFO slice.
package fwnoc_fifo_p_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // A single-entry FIFO still needs a one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwnoc_fifo_p_if.sv
// Ready-valid target (i_*) and initiator (e_*) ports of the FIFO.
interface fwnoc_fifo_p_if #(
  parameter int DAT_WIDTH = 32
);
  logic                 i_valid;
  logic                 i_ready;
  logic [DAT_WIDTH-1:0] i_dat;
  logic                 e_valid;
  logic                 e_ready;
  logic [DAT_WIDTH-1:0] e_dat;

  modport master (
    output i_valid, i_dat, e_ready,
    input  i_ready, e_valid, e_dat
  );

  modport slave (
    input  i_valid, i_dat, e_ready,
    output i_ready, e_valid, e_dat
  );
endinterface

// File: rtl/fwnoc_fifo_ptr.sv
// Circular index 0..DEPTH-1 with explicit wrap, so any DEPTH works.
module fwnoc_fifo_ptr
  import fwnoc_fifo_p_pkg::*;
#(
  parameter  int DEPTH     = 4,
  localparam int PTR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [PTR_WIDTH-1:0] ptr
);

  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fwnoc_fifo_p.sv
// Synchronous ready-valid FIFO with occupancy flags and peak-occupancy tracking.
module fwnoc_fifo_p
  import fwnoc_fifo_p_pkg::*;
#(
  parameter  int DAT_WIDTH  = 32,
  parameter  int DEPTH      = 4,
  parameter  int AFULL_LVL  = DEPTH - 1,
  parameter  int AEMPTY_LVL = 1,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1),
  localparam int PTR_WIDTH  = ptr_width(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  fwnoc_fifo_p_if.slave        bus,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] peak
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("fwnoc_fifo_p: DEPTH must be >= 1");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("fwnoc_fifo_p: AFULL_LVL must be in 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("fwnoc_fifo_p: AEMPTY_LVL must be in 0..DEPTH-1");
  end

  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_C  = CNT_WIDTH'(AFULL_LVL);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_C = CNT_WIDTH'(AEMPTY_LVL);

  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] rptr;
  logic [PTR_WIDTH-1:0] wptr;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 push;
  logic                 pop;
  fifo_op_e             op;

  function automatic logic [CNT_WIDTH-1:0] sat_peak(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic [CNT_WIDTH-1:0] nxt);
    logic [CNT_WIDTH-1:0] hi;
    hi = (nxt > cur) ? nxt : cur;
    return (hi > DEPTH_C) ? DEPTH_C : hi;
  endfunction

  // Handshake terms come from registered count only; e_ready never reaches i_ready.
  assign bus.i_ready = (count < DEPTH_C) && !flush;
  assign bus.e_valid = (count != '0) && !flush;
  assign bus.e_dat   = mem[rptr];
  assign push        = bus.i_valid && bus.i_ready;
  assign pop         = bus.e_valid && bus.e_ready;
  assign op          = fifo_op_e'({push, pop});

  always_comb begin
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      case (op)
        OP_PUSH: cnt_nxt = count + 1'b1;
        OP_POP:  cnt_nxt = count - 1'b1;
        default: cnt_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      peak  <= '0;
    end else begin
      count <= cnt_nxt;
      peak  <= flush ? '0 : sat_peak(peak, cnt_nxt);
    end
  end

  // Storage is data only: never reset, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr] <= bus.i_dat;
    end
  end

  fwnoc_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (push),
    .clr     (flush),
    .ptr     (wptr)
  );

  fwnoc_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (pop),
    .clr     (flush),
    .ptr     (rptr)
  );

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

endmodule

// File: tb/tb_fwnoc_fifo_p.sv
// Directed bench for fwnoc_fifo_p: depths 3, 4 and 8 (custom thresholds) side by side.
module tb_fwnoc_fifo_p;

  logic clock;
  logic reset_n;
  logic flush;

  fwnoc_fifo_p_if #(.DAT_WIDTH(16)) b3 ();
  fwnoc_fifo_p_if #(.DAT_WIDTH(16)) b4 ();
  fwnoc_fifo_p_if #(.DAT_WIDTH(16)) b8 ();

  logic [1:0] count3, peak3;
  logic [2:0] count4, peak4;
  logic [3:0] count8, peak8;
  logic full3, empty3, af3, ae3;
  logic full4, empty4, af4, ae4;
  logic full8, empty8, af8, ae8;

  fwnoc_fifo_p #(.DAT_WIDTH(16), .DEPTH(3)) u3 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(b3),
    .count(count3), .full(full3), .empty(empty3),
    .almost_full(af3), .almost_empty(ae3), .peak(peak3)
  );

  fwnoc_fifo_p #(.DAT_WIDTH(16), .DEPTH(4)) u4 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(b4),
    .count(count4), .full(full4), .empty(empty4),
    .almost_full(af4), .almost_empty(ae4), .peak(peak4)
  );

  fwnoc_fifo_p #(.DAT_WIDTH(16), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(2)) u8 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(b8),
    .count(count8), .full(full8), .empty(empty8),
    .almost_full(af8), .almost_empty(ae8), .peak(peak8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] dat;
    logic        er;
    int          cnt;
    logic        ev;
    logic [15:0] edat;
    logic        ir;
  } vec_t;

  vec_t tbl[13];

  logic [15:0] exp3 [5];
  logic        iv3  [5];
  logic [15:0] dat3 [5];

  initial begin
    // Inputs applied, one edge, then outputs compared against the expected post-edge state.
    tbl[0]  = '{1'b1, 16'h0011, 1'b0, 1, 1'b1, 16'h0011, 1'b1};
    tbl[1]  = '{1'b1, 16'h0022, 1'b0, 2, 1'b1, 16'h0011, 1'b1};
    tbl[2]  = '{1'b1, 16'h0033, 1'b0, 3, 1'b1, 16'h0011, 1'b1};
    tbl[3]  = '{1'b1, 16'h0044, 1'b0, 4, 1'b1, 16'h0011, 1'b0};
    tbl[4]  = '{1'b1, 16'h0055, 1'b1, 3, 1'b1, 16'h0022, 1'b1};
    tbl[5]  = '{1'b1, 16'h0055, 1'b0, 4, 1'b1, 16'h0022, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 3, 1'b1, 16'h0033, 1'b1};
    tbl[7]  = '{1'b1, 16'h0066, 1'b1, 3, 1'b1, 16'h0044, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 2, 1'b1, 16'h0055, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1, 1'b1, 16'h0066, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b1};
    tbl[11] = '{1'b1, 16'h0077, 1'b1, 1, 1'b1, 16'h0077, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b1};

    exp3 = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E};
    iv3  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    dat3 = '{16'h000D, 16'h000D, 16'h000E, 16'h0000, 16'h0000};

    flush = 1'b0;
    b3.i_valid = 1'b0; b3.i_dat = '0; b3.e_ready = 1'b0;
    b4.i_valid = 1'b0; b4.i_dat = '0; b4.e_ready = 1'b0;
    b8.i_valid = 1'b0; b8.i_dat = '0; b8.e_ready = 1'b0;

    // ---- reset values, observed before any clock edge
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_count",   32'(count4), 32'd0);
    chk("rst_peak",    32'(peak4), 32'd0);
    chk("rst_e_valid", 32'(b4.e_valid), 32'd0);
    chk("rst_i_ready", 32'(b4.i_ready), 32'd1);
    chk("rst_empty",   32'(empty4), 32'd1);
    chk("rst_full",    32'(full4), 32'd0);
    chk("rst_aempty",  32'(ae4), 32'd1);
    chk("rst_afull",   32'(af4), 32'd0);
    chk("rst_d8_afull", 32'(af8), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    step();

    // ---- DEPTH=3: fill, then drain across the 2->0 wrap while pushing D,E
    b3.i_valid = 1'b1; b3.i_dat = 16'h000A; step();
    b3.i_dat = 16'h000B; step();
    b3.i_dat = 16'h000C; step();
    b3.i_valid = 1'b0;
    chk("d3_full",    32'(full3), 32'd1);
    chk("d3_i_ready", 32'(b3.i_ready), 32'd0);
    chk("d3_count",   32'(count3), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("d3_order%0d", i), 32'(b3.e_dat), 32'(exp3[i]));
      chk($sformatf("d3_valid%0d", i), 32'(b3.e_valid), 32'd1);
      b3.e_ready = 1'b1; b3.i_valid = iv3[i]; b3.i_dat = dat3[i];
      step();
    end
    b3.e_ready = 1'b0; b3.i_valid = 1'b0;
    chk("d3_drained", 32'(count3), 32'd0);
    chk("d3_empty",   32'(empty3), 32'd1);

    // ---- DEPTH=4 table
    for (int i = 0; i < 13; i++) begin
      b4.i_valid = tbl[i].iv; b4.i_dat = tbl[i].dat; b4.e_ready = tbl[i].er;
      step();
      chk($sformatf("t%0d_count", i),   32'(count4), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_e_valid", i), 32'(b4.e_valid), 32'(tbl[i].ev));
      chk($sformatf("t%0d_i_ready", i), 32'(b4.i_ready), 32'(tbl[i].ir));
      if (tbl[i].ev) chk($sformatf("t%0d_e_dat", i), 32'(b4.e_dat), 32'(tbl[i].edat));
      chk($sformatf("t%0d_full", i),   32'(full4),  32'(tbl[i].cnt == 4));
      chk($sformatf("t%0d_empty", i),  32'(empty4), 32'(tbl[i].cnt == 0));
      chk($sformatf("t%0d_afull", i),  32'(af4),    32'(tbl[i].cnt >= 3));
      chk($sformatf("t%0d_aempty", i), 32'(ae4),    32'(tbl[i].cnt <= 1));
    end
    b4.i_valid = 1'b0; b4.e_ready = 1'b0;
    chk("d4_peak", 32'(peak4), 32'd4);

    // ---- backpressure with two entries held
    b4.i_valid = 1'b1; b4.i_dat = 16'h0101; step();
    b4.i_dat = 16'h0202; step();
    b4.i_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp%0d_e_dat", i),   32'(b4.e_dat), 32'h0101);
      chk($sformatf("bp%0d_e_valid", i), 32'(b4.e_valid), 32'd1);
      chk($sformatf("bp%0d_count", i),   32'(count4), 32'd2);
    end

    // ---- flush at count 3 with a push and pop offered
    b4.i_valid = 1'b1; b4.i_dat = 16'h0303; step();
    chk("fl_pre_count", 32'(count4), 32'd3);
    flush = 1'b1; b4.i_dat = 16'h0404; b4.e_ready = 1'b1;
    #1;
    chk("fl_i_ready", 32'(b4.i_ready), 32'd0);
    chk("fl_e_valid", 32'(b4.e_valid), 32'd0);
    step();
    flush = 1'b0; b4.i_valid = 1'b0; b4.e_ready = 1'b0;
    #1;
    chk("fl_count", 32'(count4), 32'd0);
    chk("fl_peak",  32'(peak4), 32'd0);
    chk("fl_empty", 32'(empty4), 32'd1);
    chk("fl_e_valid_after", 32'(b4.e_valid), 32'd0);
    b4.i_valid = 1'b1; b4.i_dat = 16'h0505; step();
    b4.i_valid = 1'b0;
    chk("fl_new_dat",   32'(b4.e_dat), 32'h0505);
    chk("fl_new_count", 32'(count4), 32'd1);
    b4.e_ready = 1'b1; step();
    b4.e_ready = 1'b0;
    chk("fl_clear", 32'(count4), 32'd0);

    // ---- DEPTH=8, AFULL=6, AEMPTY=2: fill to 7, drain to 1
    for (int k = 1; k <= 7; k++) begin
      b8.i_valid = 1'b1; b8.i_dat = 16'(k); step();
      chk($sformatf("d8_up%0d_count", k),  32'(count8), 32'(k));
      chk($sformatf("d8_up%0d_afull", k),  32'(af8), 32'(k >= 6));
      chk($sformatf("d8_up%0d_aempty", k), 32'(ae8), 32'(k <= 2));
    end
    b8.i_valid = 1'b0;
    for (int k = 6; k >= 1; k--) begin
      b8.e_ready = 1'b1; step();
      chk($sformatf("d8_dn%0d_count", k),  32'(count8), 32'(k));
      chk($sformatf("d8_dn%0d_afull", k),  32'(af8), 32'(k >= 6));
      chk($sformatf("d8_dn%0d_aempty", k), 32'(ae8), 32'(k <= 2));
    end
    b8.e_ready = 1'b0;
    chk("d8_peak",   32'(peak8), 32'd7);
    chk("d8_last",   32'(b8.e_dat), 32'd7);

    // ---- asynchronous reset mid-cycle with two entries held
    b4.i_valid = 1'b1; b4.i_dat = 16'h0606; step();
    b4.i_dat = 16'h0707; step();
    b4.i_valid = 1'b0;
    chk("ar_pre_count", 32'(count4), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_e_valid", 32'(b4.e_valid), 32'd0);
    chk("ar_count",   32'(count4), 32'd0);
    chk("ar_i_ready", 32'(b4.i_ready), 32'd1);
    @(negedge clock) reset_n = 1'b1;
    step();
    chk("ar_still_empty", 32'(b4.e_valid), 32'd0);
    b4.i_valid = 1'b1; b4.i_dat = 16'h0808; step();
    b4.i_valid = 1'b0;
    chk("ar_new_dat",   32'(b4.e_dat), 32'h0808);
    chk("ar_new_count", 32'(count4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
